// File: rtl/food_eat_ctrl_if.sv
// Bus between the Pac-Man motion logic / renderer and the pellet-eat controller.
//
// Handshake: frame_tick is a one-cycle request that is only accepted on a
// cycle where ready is high; Ball_X_Pos_out/Ball_Y_Pos_out must stay stable
// from that frame_tick until ready is high again. A tick while ready is low
// is dropped. level_restart needs no handshake and is honoured in any state.
//
// dbg_state encoding: 0 = LOAD, 1 = IDLE, 2 = READ, 3 = DECIDE.
interface food_eat_ctrl_if;
    logic       frame_tick;
    logic       level_restart;
    logic [9:0] Ball_X_Pos_out;
    logic [9:0] Ball_Y_Pos_out;
    logic       is_food_eaten;
    logic [15:0] score;
    logic [7:0] pellets_left;
    logic       level_clear;
    logic       ready;
    logic [1:0] dbg_state;

    modport master (
        output frame_tick, level_restart, Ball_X_Pos_out, Ball_Y_Pos_out,
        input  is_food_eaten, score, pellets_left, level_clear, ready, dbg_state
    );

    modport slave (
        input  frame_tick, level_restart, Ball_X_Pos_out, Ball_Y_Pos_out,
        output is_food_eaten, score, pellets_left, level_clear, ready, dbg_state
    );
endinterface

// File: rtl/food_eat_ctrl.sv
// Pellet-eat controller: once per frame converts Pac-Man's pixel position to a
// tile index, checks a shadow copy of the pellet map and pulses is_food_eaten
// when a pellet is consumed. Tracks score, pellets remaining and level clear.
//
// FOOD_MAP holds the initial pellet map, bit i = tile i (0 = pellet, 1 = empty).
// It is copied into the shadow RAM after reset and after every level_restart.
module food_eat_ctrl #(
    parameter int PELLET_POINTS = 10,
    parameter int MAP_COLS      = 20,
    parameter int MAP_ROWS      = 11,
    parameter logic [MAP_COLS*MAP_ROWS-1:0] FOOD_MAP = '0
) (
    input  logic Clk,
    input  logic Reset,
    food_eat_ctrl_if.slave bus
);

    localparam int DEPTH  = MAP_COLS * MAP_ROWS;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [9:0] X_LIMIT = 10'(MAP_COLS * 32);
    localparam logic [9:0] Y_LIMIT = 10'(MAP_ROWS * 32);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_READ   = 2'd2,
        ST_DECIDE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [15:0]         score_q, score_d;
    logic [7:0]          pellets_q, pellets_d;
    logic                clear_q, clear_d;
    logic                eaten_q, eaten_d;
    logic                ready_q, ready_d;

    // Shadow pellet map, single synchronous read/write port
    logic                shadow_ram [DEPTH];
    logic                ram_rd_q;
    logic                ram_we;
    logic                ram_wd;
    logic [ADDR_W-1:0]   ram_addr;

    logic                pos_valid;
    logic [ADDR_W-1:0]   tile_idx;
    logic [16:0]         score_sum;

    // Tile index of the current position and saturating score increment
    always_comb begin
        pos_valid = (bus.Ball_X_Pos_out < X_LIMIT) && (bus.Ball_Y_Pos_out < Y_LIMIT);
        tile_idx  = ADDR_W'(bus.Ball_Y_Pos_out[9:5]) * ADDR_W'(MAP_COLS)
                  + ADDR_W'(bus.Ball_X_Pos_out[9:5]);
        score_sum = {1'b0, score_q} + 17'(PELLET_POINTS);
    end

    // Next-state, RAM port control and next output values
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        score_d   = score_q;
        pellets_d = pellets_q;
        clear_d   = clear_q;
        eaten_d   = 1'b0;
        ram_we    = 1'b0;
        ram_wd    = 1'b0;
        ram_addr  = idx_q;

        if (bus.level_restart) begin
            // Restart beats everything, including a pending DECIDE and a same-cycle tick
            state_d   = ST_LOAD;
            cnt_d     = '0;
            score_d   = '0;
            pellets_d = '0;
            clear_d   = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    ram_we   = 1'b1;
                    ram_addr = cnt_q;
                    ram_wd   = FOOD_MAP[cnt_q];
                    if (!FOOD_MAP[cnt_q]) begin
                        pellets_d = pellets_q + 8'd1;
                    end
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        clear_d = (pellets_d == 8'd0);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    // ready_q gates the tick so the settle cycle after DECIDE ignores it
                    if (bus.frame_tick && ready_q && pos_valid && !clear_q) begin
                        idx_d   = tile_idx;
                        state_d = ST_READ;
                    end
                end
                ST_READ: begin
                    // RAM samples idx_q at the end of this cycle
                    state_d = ST_DECIDE;
                end
                ST_DECIDE: begin
                    if (!ram_rd_q) begin
                        ram_we    = 1'b1;
                        ram_wd    = 1'b1;
                        eaten_d   = 1'b1;
                        score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                        pellets_d = pellets_q - 8'd1;
                        if (pellets_q == 8'd1) begin
                            clear_d = 1'b1;
                        end
                    end
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_LOAD;
                end
            endcase
        end

        // Ready returns one cycle after DECIDE so the pulse cycle is never a new request
        ready_d = (state_d == ST_IDLE) && (state_q != ST_DECIDE);
    end

    // FSM state and registered outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_LOAD;
            cnt_q     <= '0;
            idx_q     <= '0;
            score_q   <= '0;
            pellets_q <= '0;
            clear_q   <= 1'b0;
            eaten_q   <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            score_q   <= score_d;
            pellets_q <= pellets_d;
            clear_q   <= clear_d;
            eaten_q   <= eaten_d;
            ready_q   <= ready_d;
        end
    end

    // Shadow RAM: read-first single port, contents rebuilt by LOAD after any reset
    always_ff @(posedge Clk) begin
        if (ram_we) begin
            shadow_ram[ram_addr] <= ram_wd;
        end
        ram_rd_q <= shadow_ram[ram_addr];
    end

    assign bus.is_food_eaten = eaten_q;
    assign bus.score         = score_q;
    assign bus.pellets_left  = pellets_q;
    assign bus.level_clear   = clear_q;
    assign bus.ready         = ready_q;
    assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_food_eat_ctrl.sv
// Bench for food_eat_ctrl: two instances (150-pellet map and 2-pellet map),
// a reference model of the pellet map / score, and a queue of expected
// results checked two cycles after each accepted-or-dropped frame tick.
module tb_food_eat_ctrl;

  localparam logic [219:0] MAP_A = {{70{1'b1}}, {150{1'b0}}};
  localparam logic [219:0] MAP_B = {1'b0, {218{1'b1}}, 1'b0};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  food_eat_ctrl_if ifa ();
  food_eat_ctrl_if ifb ();

  food_eat_ctrl #(.FOOD_MAP(MAP_A)) dut_a (.Clk(clk), .Reset(rst), .bus(ifa));
  food_eat_ctrl #(.FOOD_MAP(MAP_B)) dut_b (.Clk(clk), .Reset(rst), .bus(ifb));

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [219:0] mdl_map [2];
  int           mdl_score [2];
  int           mdl_pellets [2];
  logic         mdl_clear [2];

  function automatic int count_zeros(input logic [219:0] m);
    int n = 0;
    for (int i = 0; i < 220; i++) if (!m[i]) n++;
    return n;
  endfunction

  task automatic model_reload(input int sel);
    mdl_map[sel]     = (sel == 0) ? MAP_A : MAP_B;
    mdl_score[sel]   = 0;
    mdl_pellets[sel] = count_zeros(mdl_map[sel]);
    mdl_clear[sel]   = (mdl_pellets[sel] == 0);
  endtask

  // ---------------- scoreboard ----------------
  // record = {pulse, level_clear, score[15:0], pellets_left[7:0]}
  logic [25:0] exp_q_a[$];
  logic [25:0] exp_q_b[$];
  logic        arm_a = 1'b0;
  logic        arm_b = 1'b0;
  logic [2:0]  arm_pipe_a = '0;
  logic [2:0]  arm_pipe_b = '0;

  always @(posedge clk) begin
    arm_pipe_a <= {arm_pipe_a[1:0], arm_a};
    arm_pipe_b <= {arm_pipe_b[1:0], arm_b};
  end

  task automatic compare_rec(input string tag, input logic p, input logic c,
                             input logic [15:0] s, input logic [7:0] pl, input logic [25:0] e);
    check({"pulse_", tag}, p, e[25]);
    check({"clear_", tag}, c, e[24]);
    check({"score_", tag}, s, e[23:8]);
    check({"pellets_", tag}, pl, e[7:0]);
  endtask

  always @(negedge clk) begin
    logic [25:0] e;
    if (!rst) begin
      if (arm_pipe_a[2]) begin
        if (exp_q_a.size() == 0) check("sb_underflow_a", exp_q_a.size(), 1);
        else begin
          e = exp_q_a.pop_front();
          compare_rec("a", ifa.is_food_eaten, ifa.level_clear, ifa.score, ifa.pellets_left, e);
        end
      end else if (ifa.is_food_eaten) check("stray_pulse_a", ifa.is_food_eaten, 0);
      if (arm_pipe_b[2]) begin
        if (exp_q_b.size() == 0) check("sb_underflow_b", exp_q_b.size(), 1);
        else begin
          e = exp_q_b.pop_front();
          compare_rec("b", ifb.is_food_eaten, ifb.level_clear, ifb.score, ifb.pellets_left, e);
        end
      end else if (ifb.is_food_eaten) check("stray_pulse_b", ifb.is_food_eaten, 0);
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic rdy(input int sel);
    return (sel == 0) ? ifa.ready : ifb.ready;
  endfunction

  task automatic drive(input int sel, input logic tick, input logic arm,
                       input logic [9:0] x, input logic [9:0] y);
    if (sel == 0) begin
      ifa.frame_tick = tick; ifa.Ball_X_Pos_out = x; ifa.Ball_Y_Pos_out = y; arm_a = arm;
    end else begin
      ifb.frame_tick = tick; ifb.Ball_X_Pos_out = x; ifb.Ball_Y_Pos_out = y; arm_b = arm;
    end
  endtask

  task automatic wait_ready(input int sel, input int budget, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (rdy(sel)) break;
      if (n >= budget) begin
        check("ready_timeout", rdy(sel), 1);
        break;
      end
    end
  endtask

  task automatic do_tick(input int sel, input int x, input int y);
    int n;
    int idx;
    logic valid, accepted, hit;
    wait_ready(sel, 300, n);
    valid    = (x < 640) && (y < 352);
    idx      = (y / 32) * 20 + (x / 32);
    accepted = valid && !mdl_clear[sel];
    hit      = 1'b0;
    if (accepted) hit = (mdl_map[sel][idx] == 1'b0);
    if (hit) begin
      mdl_map[sel][idx] = 1'b1;
      mdl_score[sel]    = (mdl_score[sel] + 10 > 65535) ? 65535 : mdl_score[sel] + 10;
      mdl_pellets[sel]--;
      if (mdl_pellets[sel] == 0) mdl_clear[sel] = 1'b1;
    end
    if (sel == 0) exp_q_a.push_back({hit, mdl_clear[sel], 16'(mdl_score[sel]), 8'(mdl_pellets[sel])});
    else          exp_q_b.push_back({hit, mdl_clear[sel], 16'(mdl_score[sel]), 8'(mdl_pellets[sel])});
    drive(sel, 1'b1, 1'b1, 10'(x), 10'(y));
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 10'(x), 10'(y));
    check("ready_after_tick", rdy(sel), {31'd0, !accepted});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int pick;
    int px, py;

    drive(0, 1'b0, 1'b0, 10'd0, 10'd0);
    drive(1, 1'b0, 1'b0, 10'd0, 10'd0);
    ifa.level_restart = 1'b0;
    ifb.level_restart = 1'b0;

    // reset values while Reset is held
    repeat (3) @(negedge clk);
    check("rst_ready", ifa.ready, 0);
    check("rst_pulse", ifa.is_food_eaten, 0);
    check("rst_score", ifa.score, 0);
    check("rst_pellets", ifa.pellets_left, 0);
    check("rst_clear", ifa.level_clear, 0);
    check("rst_state", ifa.dbg_state, 0);

    // release and time the initial load
    rst = 1'b0;
    model_reload(0);
    model_reload(1);
    wait_ready(0, 400, n);
    check("load_cycles", n, 220);
    check("load_ready_b", ifb.ready, 1);
    check("load_pellets_a", ifa.pellets_left, 150);
    check("load_score_a", ifa.score, 0);
    check("load_clear_a", ifa.level_clear, 0);
    check("load_state_a", ifa.dbg_state, 1);
    check("load_pellets_b", ifb.pellets_left, 2);
    check("load_clear_b", ifb.level_clear, 0);

    // first eat, repeat visit, out-of-range positions
    do_tick(0, 40, 70);
    do_tick(0, 40, 70);
    do_tick(0, 650, 10);
    do_tick(0, 10, 360);
    do_tick(0, 639, 351);

    // random positions, some on the map, some beyond it
    for (int i = 0; i < 24; i++) begin
      do_tick(0, $urandom_range(0, 700), $urandom_range(0, 400));
    end

    // level_restart during READ: no pulse, full reload
    pick = 0;
    for (int i = 219; i >= 0; i--) if (!mdl_map[0][i]) pick = i;
    px = (pick % 20) * 32 + 3;
    py = (pick / 20) * 32 + 3;
    wait_ready(0, 300, n);
    drive(0, 1'b1, 1'b0, 10'(px), 10'(py));
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 10'(px), 10'(py));
    ifa.level_restart = 1'b1;
    @(negedge clk);
    ifa.level_restart = 1'b0;
    check("restart_ready", ifa.ready, 0);
    check("restart_score", ifa.score, 0);
    model_reload(0);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      // a tick mid-load must be ignored
      if (n == 50) drive(0, 1'b1, 1'b0, 10'(px), 10'(py));
      if (n == 51) drive(0, 1'b0, 1'b0, 10'(px), 10'(py));
      if (ifa.ready) break;
      if (n >= 400) begin
        check("reload_timeout", ifa.ready, 1);
        break;
      end
    end
    check("reload_cycles", n, 220);
    check("reload_score", ifa.score, 0);
    check("reload_pellets", ifa.pellets_left, 150);
    check("reload_clear", ifa.level_clear, 0);
    do_tick(0, px, py);
    do_tick(0, 40, 70);

    // two-pellet map: eat both, then nothing more
    do_tick(1, 0, 0);
    do_tick(1, 620, 340);
    do_tick(1, 0, 0);
    do_tick(1, 100, 100);

    repeat (6) @(negedge clk);
    check("sb_drain_a", exp_q_a.size(), 0);
    check("sb_drain_b", exp_q_b.size(), 0);
    check("final_clear_b", ifb.level_clear, 1);
    check("final_pellets_b", ifb.pellets_left, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/food_eat_ctrl.md
Name: food_eat_ctrl

Overview:
- Upstream of the pellet renderer in the Pac-Man datapath; sits between Pac-Man motion logic and the food bitmap block.
- Once per frame it samples Pac-Man's position and converts it to a 32x32 tile index.
- Checks its own shadow copy of the pellet map. On a hit it issues the one-cycle is_food_eaten pulse that makes the renderer clear that tile.
- Also tracks score, pellets remaining and level-clear, and reloads the map on reset or level restart.

Parameters:
- FOOD_FILE, "sprite_bytes/food.txt", hex init file for the 220-entry pellet map (0 = pellet, 1 = empty).
- PELLET_POINTS, 10, score increment per pellet eaten.
- MAP_COLS, 20, tiles per row.
- MAP_ROWS, 11, tile rows; map depth is MAP_COLS*MAP_ROWS = 220.

Ports:
- Clk  in  1  50 MHz system clock.
- Reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame, synchronous to Clk.
- level_restart  in  1  one-cycle pulse; reloads the map and clears score.
- Ball_X_Pos_out  in  10  Pac-Man X pixel position; stable from frame_tick until ready returns high.
- Ball_Y_Pos_out  in  10  Pac-Man Y pixel position; same stability rule as X.
- is_food_eaten  out  1  one-cycle pulse; the tile at the current position must be cleared.
- score  out  16  accumulated points.
- pellets_left  out  8  pellets remaining.
- level_clear  out  1  high when pellets_left == 0 after a load.
- ready  out  1  high in IDLE only.

Behaviour:
- Storage:
  - Internal read-only ROM of 220 x 1 bit, loaded from FOOD_FILE.
  - Separate 220 x 1 shadow RAM with one synchronous read/write port.
- Tile index: idx = (Y>>5)*MAP_COLS + (X>>5). It is valid only when X < 640 and Y < 352.
- Reset (async, asserted): state = LOAD, load counter = 0, score = 0, pellets_left = 0, is_food_eaten = 0, level_clear = 0, ready = 0.
- LOAD state:
  - Each cycle: copy ROM[cnt] into RAM[cnt]; increment pellets_left when the entry is 0; cnt++.
  - After entry 219 has been written, go to IDLE. LOAD lasts exactly 220 cycles.
  - frame_tick is ignored during LOAD.
- IDLE state:
  - ready = 1.
  - On frame_tick with a valid idx and level_clear = 0: latch idx, go to READ.
  - On frame_tick with an invalid idx, or while level_clear = 1: stay in IDLE; no pulse.
- READ state: issue RAM read at the latched idx; go to DECIDE.
- DECIDE state:
  - If read data == 0: write RAM[idx] = 1, assert is_food_eaten for this single cycle, score += PELLET_POINTS (saturating at 16'hFFFF), pellets_left -= 1.
  - Go to IDLE in either case.
- Latency: frame_tick sampled at edge t; is_food_eaten is high during cycle t+2 → t+3; ready is high again at t+3.
- Repeat visits: a tile already eaten reads 1, so no pulse and no score change. Parking on one tile yields exactly one pulse.
- level_clear:
  - Registered; set on the cycle pellets_left becomes 0, or at LOAD exit if the map holds 0 pellets.
  - Cleared only by Reset or level_restart.
- level_restart:
  - Accepted in any state.
  - Aborts any in-flight check; a pending DECIDE produces no pulse.
  - Clears score, pellets_left and level_clear, resets cnt = 0, enters LOAD.
- Simultaneous level_restart and frame_tick: restart wins; the tick is dropped.
- Reset asserted mid-LOAD or mid-check: immediate return to the reset values, then a full reload.
- pellets_left never underflows; the decrement only happens on a read of 0, which requires pellets_left ≥ 1.

Test Plan:
- Reset released with a map of 150 zeros → ready rises exactly 220 cycles later; pellets_left = 150, score = 0, level_clear = 0.
- Position (X=40, Y=70), idx 41 holds a pellet; frame_tick at t → is_food_eaten high only in cycle t+2; score = 10, pellets_left = 149.
- Same position, second frame_tick → no pulse; score stays 10; pellets_left stays 149.
- Position (X=650, Y=10) and (X=10, Y=360), each with frame_tick → no pulse, no RAM write, ready stays high.
- Map with 2 pellets; eat both → level_clear rises in the cycle of the second pulse; a further frame_tick on any pellet tile produces no pulse.
- level_restart issued in the READ cycle → no pulse; 220-cycle reload follows; score = 0, pellets_left restored to the file count.
